// File: rtl/tb_ram_arbiter.sv
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Two-master round-robin arbiter sharing one 1-cycle-latency RAM
//             data port (m0 = core data port, m1 = bench loader/stimulus).
//             Optional statistics counters: define TB_RAM_ARB_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      m0_req_i,
    input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
    input  logic                      m0_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_be_i,
    input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
    output logic                      m0_gnt_o,
    output logic                      m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]     m0_rdata_o,

    input  logic                      m1_req_i,
    input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
    input  logic                      m1_we_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
    input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
    output logic                      m1_gnt_o,
    output logic                      m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]     m1_rdata_o,

    output logic                      ram_en_o,
    output logic                      ram_we_o,
    output logic [ADDR_WIDTH-1:0]     ram_addr_o,
    output logic [DATA_WIDTH/8-1:0]   ram_be_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]     ram_rdata_i,

    output logic [CNT_WIDTH-1:0]      gnt_cnt0_o,
    output logic [CNT_WIDTH-1:0]      gnt_cnt1_o,
    output logic [CNT_WIDTH-1:0]      conflict_cnt_o
);

    // r_prio: index of the master that wins the next conflict
    logic r_prio;
    logic r_rsp_valid;
    logic r_rsp_owner;
    logic r_rsp_we;

    logic w_gnt0;
    logic w_gnt1;
    logic w_any_gnt;
    logic w_prio_nxt;
    logic w_rsp_live;

    // ------------------------------------------------------------------
    // Arbitration decision (combinational, same cycle as request)
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt0    = m0_req_i & (~m1_req_i | ~r_prio);
        w_gnt1    = m1_req_i & (~m0_req_i |  r_prio);
        w_any_gnt = w_gnt0 | w_gnt1;
    end

    // Loser of this cycle's grant becomes the preferred master
    always_comb begin
        w_prio_nxt = r_prio;
        if (w_gnt0) begin
            w_prio_nxt = 1'b1;
        end else if (w_gnt1) begin
            w_prio_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_owner <= 1'b0;
            r_rsp_we    <= 1'b0;
        end else begin
            r_prio      <= w_prio_nxt;
            r_rsp_valid <= w_any_gnt;
            r_rsp_owner <= w_gnt1;
            r_rsp_we    <= w_gnt1 ? m1_we_i : m0_we_i;
        end
    end

    // ------------------------------------------------------------------
    // RAM port mux; all-zero when idle
    // ------------------------------------------------------------------
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (w_gnt0) begin
            ram_en_o    = 1'b1;
            ram_we_o    = m0_we_i;
            ram_addr_o  = m0_addr_i;
            ram_be_o    = m0_be_i;
            ram_wdata_o = m0_wdata_i;
        end else if (w_gnt1) begin
            ram_en_o    = 1'b1;
            ram_we_o    = m1_we_i;
            ram_addr_o  = m1_addr_i;
            ram_be_o    = m1_be_i;
            ram_wdata_o = m1_wdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Grants and responses; a response pending when reset arrives is
    // suppressed so it is never presented to its master.
    // ------------------------------------------------------------------
    always_comb begin
        w_rsp_live  = r_rsp_valid & ~rst_i;
        m0_gnt_o    = w_gnt0;
        m1_gnt_o    = w_gnt1;
        m0_rvalid_o = w_rsp_live & ~r_rsp_owner;
        m1_rvalid_o = w_rsp_live &  r_rsp_owner;
        m0_rdata_o  = (m0_rvalid_o && !r_rsp_we) ? ram_rdata_i : '0;
        m1_rdata_o  = (m1_rvalid_o && !r_rsp_we) ? ram_rdata_i : '0;
    end

`ifdef TB_RAM_ARB_STATS_EN
    logic                 w_conflict;
    logic [CNT_WIDTH-1:0] r_gnt_cnt0;
    logic [CNT_WIDTH-1:0] r_gnt_cnt1;
    logic [CNT_WIDTH-1:0] r_conflict_cnt;

    always_comb begin
        w_conflict = m0_req_i & m1_req_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gnt_cnt0     <= '0;
            r_gnt_cnt1     <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_gnt0) begin
                r_gnt_cnt0 <= r_gnt_cnt0 + CNT_WIDTH'(1);
            end
            if (w_gnt1) begin
                r_gnt_cnt1 <= r_gnt_cnt1 + CNT_WIDTH'(1);
            end
            if (w_conflict) begin
                r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign gnt_cnt0_o     = r_gnt_cnt0;
    assign gnt_cnt1_o     = r_gnt_cnt1;
    assign conflict_cnt_o = r_conflict_cnt;
`else
    assign gnt_cnt0_o     = '0;
    assign gnt_cnt1_o     = '0;
    assign conflict_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tb_ram_arbiter.sv
// ============================================================================
//  Module   : tb_tb_ram_arbiter
//  Purpose  : Randomized self-checking bench for tb_ram_arbiter against a
//             transaction-level reference model and a behavioural RAM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tb_ram_arbiter;

    typedef struct {
        logic [21:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [21:0] m0_addr = '0, m1_addr = '0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [3:0]  m0_be = '0, m1_be = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en, ram_we;
    logic [21:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] gnt_cnt0, gnt_cnt1, conflict_cnt;

    tb_ram_arbiter #(.ADDR_WIDTH(22), .DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_be_o(ram_be),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
        .gnt_cnt0_o(gnt_cnt0), .gnt_cnt1_o(gnt_cnt1), .conflict_cnt_o(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural RAM, one-cycle read latency, read-before-write
    logic        ram_clear = 1'b1;
    logic [31:0] ram_mem [0:1023];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= '0;
            ram_rdata <= '0;
        end else if (ram_en) begin
            ram_rdata <= ram_mem[ram_addr[11:2]];
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) ram_mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // Reference model state
    txn_t        q0[$], q1[$];
    logic [31:0] ref_mem [0:1023];
    int          mdl_prio, pend_owner;
    bit          pend_valid, pend_we;
    logic [31:0] pend_data;
    int          mdl_cnt0, mdl_cnt1, mdl_cntc;
    logic [31:0] last_rdata0, last_rdata1;
    bit          seen_rv1;
    logic [1:0]  first_gnt;
    int          n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pre_val(input int a);
        return 32'hC0DE0000 | 32'(a);
    endfunction

    function automatic txn_t mk(input int a, input bit we, input logic [3:0] be, input logic [31:0] d);
        txn_t t;
        t.addr = 22'(a); t.we = we; t.be = be; t.wdata = d;
        return t;
    endfunction

    task automatic drive();
        txn_t z;
        z = mk(0, 1'b0, 4'h0, 32'h0);
        m0_req = (q0.size() != 0);
        m1_req = (q1.size() != 0);
        if (m0_req) z = q0[0]; else z = mk(0, 1'b0, 4'h0, 32'h0);
        m0_addr = z.addr; m0_we = z.we; m0_be = z.be; m0_wdata = z.wdata;
        if (m1_req) z = q1[0]; else z = mk(0, 1'b0, 4'h0, 32'h0);
        m1_addr = z.addr; m1_we = z.we; m1_be = z.be; m1_wdata = z.wdata;
    endtask

    // One clock cycle: check all outputs against the model, then advance it
    task automatic cycle(output bit g0, output bit g1);
        int          winner;
        txn_t        t;
        bit          live;
        logic [31:0] erd, w;
        @(negedge clk);
        if (m0_req && m1_req) winner = mdl_prio;
        else if (m0_req)      winner = 0;
        else if (m1_req)      winner = 1;
        else                  winner = -1;
        t = mk(0, 1'b0, 4'h0, 32'h0);
        if (winner == 0) t = q0[0];
        if (winner == 1) t = q1[0];

        check("gnt", {62'd0, m1_gnt, m0_gnt}, {62'd0, winner == 1, winner == 0});
        check("ram_port", {4'd0, ram_en, ram_we, ram_addr, ram_be, ram_wdata},
              {4'd0, winner >= 0, t.we, t.addr, t.be, t.wdata});
        live = pend_valid && !rst;
        erd  = (live && !pend_we) ? pend_data : 32'h0;
        check("rvalid", {62'd0, m1_rvalid, m0_rvalid},
              {62'd0, live && pend_owner == 1, live && pend_owner == 0});
        check("rdata0", 64'(m0_rdata), 64'((live && pend_owner == 0) ? erd : 32'h0));
        check("rdata1", 64'(m1_rdata), 64'((live && pend_owner == 1) ? erd : 32'h0));
`ifdef TB_RAM_ARB_STATS_EN
        check("gnt_cnt0", 64'(gnt_cnt0), 64'(32'(mdl_cnt0)));
        check("gnt_cnt1", 64'(gnt_cnt1), 64'(32'(mdl_cnt1)));
        check("conflict_cnt", 64'(conflict_cnt), 64'(32'(mdl_cntc)));
`else
        check("stats_tied", {gnt_cnt0, gnt_cnt1 | conflict_cnt}, 64'd0);
`endif
        if (m0_rvalid) last_rdata0 = m0_rdata;
        if (m1_rvalid) begin last_rdata1 = m1_rdata; seen_rv1 = 1'b1; end
        first_gnt = {m1_gnt, m0_gnt};

        if (rst) begin
            mdl_prio = 0; pend_valid = 1'b0;
            mdl_cnt0 = 0; mdl_cnt1 = 0; mdl_cntc = 0;
        end else begin
            if (m0_req && m1_req) mdl_cntc++;
            pend_valid = (winner >= 0);
            if (winner >= 0) begin
                pend_owner = winner;
                pend_we    = t.we;
                pend_data  = ref_mem[t.addr[11:2]];
                if (t.we) begin
                    w = ref_mem[t.addr[11:2]];
                    for (int b = 0; b < 4; b++) if (t.be[b]) w[8*b +: 8] = t.wdata[8*b +: 8];
                    ref_mem[t.addr[11:2]] = w;
                end
                mdl_prio = 1 - winner;
                if (winner == 0) mdl_cnt0++; else mdl_cnt1++;
            end
        end
        g0 = (winner == 0);
        g1 = (winner == 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int budget, output int ncyc, output logic [1:0] fg);
        bit g0, g1;
        ncyc = 0;
        fg   = 2'b00;
        while ((q0.size() != 0 || q1.size() != 0) && ncyc < budget) begin
            drive();
            cycle(g0, g1);
            if (ncyc == 0) fg = first_gnt;
            if (g0) void'(q0.pop_front());
            if (g1) void'(q1.pop_front());
            ncyc++;
        end
        check("run_drained", 64'(q0.size() + q1.size()), 64'd0);
        q0.delete(); q1.delete();
        drive();
        cycle(g0, g1);
    endtask

    task automatic do_reset(input int n);
        bit g0, g1;
        rst = 1'b1;
        q0.delete(); q1.delete();
        drive();
        repeat (n) cycle(g0, g1);
        rst = 1'b0;
    endtask

    initial begin
        int          nc;
        logic [1:0]  fg;
        bit          g0, g1;
        txn_t        t;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        mdl_prio = 0; pend_valid = 0; pend_owner = 0; pend_we = 0; pend_data = '0;
        mdl_cnt0 = 0; mdl_cnt1 = 0; mdl_cntc = 0;
        last_rdata0 = '0; last_rdata1 = '0; seen_rv1 = 0; first_gnt = '0;
        @(posedge clk); #1;
        ram_clear = 1'b0;

        // Reset, then first conflict must go to m0
        do_reset(3);
        q0.push_back(mk(32'h0, 1'b0, 4'hF, 32'h0));
        q1.push_back(mk(32'h4, 1'b0, 4'hF, 32'h0));
        run(10, nc, fg);
        check("first_conflict_gnt", 64'(fg), 64'd1);

        // Single master write then read-back
        seen_rv1 = 0;
        q0.push_back(mk(32'h100, 1'b1, 4'hF, 32'hDEADBEEF));
        q0.push_back(mk(32'h100, 1'b0, 4'hF, 32'h0));
        run(10, nc, fg);
        check("single_cycles", 64'(nc), 64'd2);
        check("single_rdata", 64'(last_rdata0), 64'h0000_0000_DEAD_BEEF);
        check("single_m1_rvalid", 64'(seen_rv1), 64'd0);

        // Preload via the loader master, then sustained conflict from reset
        for (int i = 0; i < 6; i++) begin
            q1.push_back(mk(4*i, 1'b1, 4'hF, pre_val(4*i)));
            q1.push_back(mk(32'h200 + 4*i, 1'b1, 4'hF, pre_val(32'h200 + 4*i)));
        end
        run(20, nc, fg);
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            q0.push_back(mk(4*i, 1'b0, 4'hF, 32'h0));
            q1.push_back(mk(32'h200 + 4*i, 1'b0, 4'hF, 32'h0));
        end
        run(30, nc, fg);
        check("conflict_cycles", 64'(nc), 64'd12);
        check("conflict_last_rd0", 64'(last_rdata0), 64'(pre_val(32'h14)));
        check("conflict_last_rd1", 64'(last_rdata1), 64'(pre_val(32'h214)));
`ifdef TB_RAM_ARB_STATS_EN
        check("stat_gnt0", 64'(gnt_cnt0), 64'd6);
        check("stat_gnt1", 64'(gnt_cnt1), 64'd6);
        check("stat_conflict", 64'(conflict_cnt), 64'd11);
`else
        check("stat_off_gnt0", 64'(gnt_cnt0), 64'd0);
        check("stat_off_gnt1", 64'(gnt_cnt1), 64'd0);
        check("stat_off_conflict", 64'(conflict_cnt), 64'd0);
`endif

        // Byte-lane merge
        q1.push_back(mk(32'h40, 1'b1, 4'hF, 32'h11223344));
        q1.push_back(mk(32'h40, 1'b1, 4'h1, 32'h000000AA));
        run(10, nc, fg);
        q0.push_back(mk(32'h40, 1'b0, 4'hF, 32'h0));
        run(10, nc, fg);
        check("byte_merge", 64'(last_rdata0), 64'h0000_0000_1122_33AA);

        // Reset arriving while m1's read response is pending
        q1.push_back(mk(32'h200, 1'b0, 4'hF, 32'h0));
        drive();
        cycle(g0, g1);
        check("mid_rst_grant", 64'(g1), 64'd1);
        q1.delete();
        seen_rv1 = 0;
        do_reset(2);
        check("mid_rst_rvalid", 64'(seen_rv1), 64'd0);
        q0.push_back(mk(32'h8, 1'b0, 4'hF, 32'h0));
        q1.push_back(mk(32'h208, 1'b0, 4'hF, 32'h0));
        run(10, nc, fg);
        check("mid_rst_prio", 64'(fg), 64'd1);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (q0.size() == 0 && $urandom_range(0, 3) != 0) begin
                t = mk(32'($urandom_range(0, 1023)) << 2, 1'($urandom_range(0, 1)),
                       4'($urandom), $urandom);
                q0.push_back(t);
            end
            if (q1.size() == 0 && $urandom_range(0, 3) != 0) begin
                t = mk(32'($urandom_range(0, 1023)) << 2, 1'($urandom_range(0, 1)),
                       4'($urandom), $urandom);
                q1.push_back(t);
            end
            drive();
            cycle(g0, g1);
            if (g0) void'(q0.pop_front());
            if (g1) void'(q1.pop_front());
        end
        run(10, nc, fg);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
